// File: rtl/cajero_parametrizado_pkg.sv
// ---------------------------------------------------------------------------
// cajero_parametrizado_pkg
// Shared definitions for the ATM session controller:
//   - NIBBLE_W : width of one BCD PIN digit
//   - estado_t : one-hot FSM state encoding
// ---------------------------------------------------------------------------
package cajero_parametrizado_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [6:0] {
    ESPERA_TARJETA = 7'b0000001,
    ESPERA_DIGITO  = 7'b0000010,
    VERIFICA       = 7'b0000100,
    ESPERA_MONTO   = 7'b0001000,
    DEPOSITO       = 7'b0010000,
    RETIRO         = 7'b0100000,
    BLOQUEADO      = 7'b1000000
  } estado_t;

endpackage

// File: rtl/cajero_temporizador.sv
// ---------------------------------------------------------------------------
// cajero_temporizador
// Inactivity timer for the ATM session controller.
// Ports:
//   CLK    in  clock, rising edge
//   RESET  in  asynchronous active-low reset
//   en     in  count while high; counter is held at zero while low
//   clr    in  restart the idle count (any user strobe)
//   expira out one-cycle pulse on the TIMEOUT_CICLOS-th consecutive idle cycle
// ---------------------------------------------------------------------------
module cajero_temporizador #(
  parameter int TIMEOUT_CICLOS = 1024
) (
  input  logic CLK,
  input  logic RESET,
  input  logic en,
  input  logic clr,
  output logic expira
);

  localparam int CW = $clog2(TIMEOUT_CICLOS + 1);

  logic [CW-1:0] cnt;

  // Holding the count at zero while disabled means every entry into a
  // counting state starts from a clean count without an explicit entry flag.
  assign expira = en && !clr && (cnt == CW'(TIMEOUT_CICLOS - 1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt <= '0;
    end else if (!en || clr || expira) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cajero_parametrizado.sv
// ---------------------------------------------------------------------------
// cajero_parametrizado
// ATM session controller: card detect, PIN entry/verification with attempt
// lock, multi-transaction sessions with deposit/withdrawal, per-session
// withdrawal limit, inactivity timeout, user cancel and balance saturation.
// Ports:
//   CLK, RESET (async active-low)
//   TARJETA_RECIBIDA      card present (level)
//   DIGITO_STB / DIGITO   keypad digit strobe and BCD value (10..15 ignored)
//   PIN                   stored PIN, first digit in the MS nibble
//   MONTO_STB / TIPO_TRANS / MONTO  transaction request (1 = withdrawal)
//   CANCELAR              end session
//   BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES,
//   LIMITE_EXCEDIDO, PIN_INCORRECTO, TIEMPO_AGOTADO   1-cycle pulses
//   ADVERTENCIA, BLOQUEO  levels
//   BALANCE               current balance (registered)
// ---------------------------------------------------------------------------
module cajero_parametrizado
  import cajero_parametrizado_pkg::*;
#(
  parameter int                   N_DIGITOS       = 4,
  parameter int                   MAX_INTENTOS    = 3,
  parameter int                   MONTO_W         = 32,
  parameter int                   BALANCE_W       = 64,
  parameter logic [BALANCE_W-1:0] BALANCE_INICIAL = 'h1000000,
  parameter logic [BALANCE_W:0]   LIMITE_RETIRO   = 'h10000,
  parameter int                   TIMEOUT_CICLOS  = 1024
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         TARJETA_RECIBIDA,
  input  logic                         DIGITO_STB,
  input  logic [3:0]                   DIGITO,
  input  logic [NIBBLE_W*N_DIGITOS-1:0] PIN,
  input  logic                         MONTO_STB,
  input  logic                         TIPO_TRANS,
  input  logic [MONTO_W-1:0]           MONTO,
  input  logic                         CANCELAR,
  output logic                         BALANCE_ACTUALIZADO,
  output logic                         ENTREGAR_DINERO,
  output logic                         FONDOS_INSUFICIENTES,
  output logic                         LIMITE_EXCEDIDO,
  output logic                         PIN_INCORRECTO,
  output logic                         ADVERTENCIA,
  output logic                         BLOQUEO,
  output logic                         TIEMPO_AGOTADO,
  output logic [BALANCE_W-1:0]         BALANCE
);

  localparam int PIN_W = NIBBLE_W * N_DIGITOS;
  localparam int CNT_W = $clog2(N_DIGITOS + 1);
  localparam int INT_W = $clog2(MAX_INTENTOS + 1);

  function automatic logic [BALANCE_W-1:0] sat_add(input logic [BALANCE_W-1:0] a,
                                                  input logic [BALANCE_W-1:0] b);
    logic [BALANCE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[BALANCE_W] ? {BALANCE_W{1'b1}} : s[BALANCE_W-1:0];
  endfunction

  estado_t            estado;
  logic [PIN_W-1:0]   pin_comp;
  logic [CNT_W-1:0]   cuenta;
  logic [INT_W-1:0]   intentos;
  logic [MONTO_W-1:0] monto_r;
  logic [BALANCE_W:0] retirado;

  logic [BALANCE_W-1:0] monto_ext;
  logic [BALANCE_W:0]   retirado_sig;
  logic [INT_W-1:0]     intentos_sig;
  logic                 digito_ok;
  logic                 ultimo_digito;
  logic                 t_en;
  logic                 t_clr;
  logic                 expira;

  assign monto_ext     = BALANCE_W'(monto_r);
  assign retirado_sig  = retirado + {1'b0, monto_ext};
  assign intentos_sig  = intentos + 1'b1;
  assign digito_ok     = DIGITO_STB && (DIGITO <= 4'd9);
  assign ultimo_digito = (cuenta == CNT_W'(N_DIGITOS - 1));
  assign t_en          = (estado == ESPERA_DIGITO) || (estado == ESPERA_MONTO);
  assign t_clr         = DIGITO_STB || MONTO_STB;

  cajero_temporizador #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
  ) u_temporizador (
    .CLK   (CLK),
    .RESET (RESET),
    .en    (t_en),
    .clr   (t_clr),
    .expira(expira)
  );

  // Amount register carries no reset; it is always written before use.
  always_ff @(posedge CLK) begin
    if ((estado == ESPERA_MONTO) && MONTO_STB) begin
      monto_r <= MONTO;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      estado               <= ESPERA_TARJETA;
      pin_comp             <= '0;
      cuenta               <= '0;
      intentos             <= '0;
      retirado             <= '0;
      BALANCE              <= BALANCE_INICIAL;
      BALANCE_ACTUALIZADO  <= 1'b0;
      ENTREGAR_DINERO      <= 1'b0;
      FONDOS_INSUFICIENTES <= 1'b0;
      LIMITE_EXCEDIDO      <= 1'b0;
      PIN_INCORRECTO       <= 1'b0;
      ADVERTENCIA          <= 1'b0;
      BLOQUEO              <= 1'b0;
      TIEMPO_AGOTADO       <= 1'b0;
    end else begin
      BALANCE_ACTUALIZADO  <= 1'b0;
      ENTREGAR_DINERO      <= 1'b0;
      FONDOS_INSUFICIENTES <= 1'b0;
      LIMITE_EXCEDIDO      <= 1'b0;
      PIN_INCORRECTO       <= 1'b0;
      TIEMPO_AGOTADO       <= 1'b0;
      unique case (estado)
        ESPERA_TARJETA: begin
          pin_comp <= '0;
          cuenta   <= '0;
          retirado <= '0;
          if (TARJETA_RECIBIDA) estado <= ESPERA_DIGITO;
        end
        ESPERA_DIGITO: begin
          if (CANCELAR) begin
            estado <= ESPERA_TARJETA;
          end else if (expira) begin
            TIEMPO_AGOTADO <= 1'b1;
            estado         <= ESPERA_TARJETA;
          end else if (digito_ok) begin
            pin_comp <= PIN_W'({pin_comp, DIGITO});
            if (ultimo_digito) begin
              cuenta <= '0;
              estado <= VERIFICA;
            end else begin
              cuenta <= cuenta + 1'b1;
            end
          end
        end
        VERIFICA: begin
          if (CANCELAR) begin
            estado <= ESPERA_TARJETA;
          end else if (pin_comp == PIN) begin
            intentos    <= '0;
            ADVERTENCIA <= 1'b0;
            estado      <= ESPERA_MONTO;
          end else if (intentos_sig == INT_W'(MAX_INTENTOS)) begin
            intentos    <= intentos_sig;
            BLOQUEO     <= 1'b1;
            ADVERTENCIA <= 1'b1;
            estado      <= BLOQUEADO;
          end else begin
            intentos       <= intentos_sig;
            PIN_INCORRECTO <= 1'b1;
            ADVERTENCIA    <= (intentos_sig == INT_W'(MAX_INTENTOS - 1));
            pin_comp       <= '0;
            cuenta         <= '0;
            estado         <= ESPERA_DIGITO;
          end
        end
        ESPERA_MONTO: begin
          if (CANCELAR) begin
            estado <= ESPERA_TARJETA;
          end else if (expira) begin
            TIEMPO_AGOTADO <= 1'b1;
            estado         <= ESPERA_TARJETA;
          end else if (MONTO_STB) begin
            estado <= TIPO_TRANS ? RETIRO : DEPOSITO;
          end
        end
        DEPOSITO: begin
          BALANCE             <= sat_add(BALANCE, monto_ext);
          BALANCE_ACTUALIZADO <= 1'b1;
          estado              <= ESPERA_MONTO;
        end
        RETIRO: begin
          if (monto_ext > BALANCE) begin
            FONDOS_INSUFICIENTES <= 1'b1;
          end else if (retirado_sig > LIMITE_RETIRO) begin
            LIMITE_EXCEDIDO <= 1'b1;
          end else begin
            BALANCE             <= BALANCE - monto_ext;
            retirado            <= retirado_sig;
            ENTREGAR_DINERO     <= 1'b1;
            BALANCE_ACTUALIZADO <= 1'b1;
          end
          estado <= ESPERA_MONTO;
        end
        BLOQUEADO: begin
          estado <= BLOQUEADO;
        end
        default: begin
          estado <= ESPERA_TARJETA;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cajero_parametrizado.sv
// ---------------------------------------------------------------------------
// tb_cajero_parametrizado
// Scoreboard bench for the ATM session controller. Stimulus tasks update a
// session-level account model and queue the expected output event; a monitor
// pops and compares whenever the DUT raises a pulse or enters lock.
// A second instance with a near-full balance shares the stimulus and is used
// for the saturation check.
// ---------------------------------------------------------------------------
module tb_cajero_parametrizado;

  localparam int MAX_INT = 3;
  localparam logic [5:0] P_BAL = 6'b100000;
  localparam logic [5:0] P_ENT = 6'b010000;
  localparam logic [5:0] P_FON = 6'b001000;
  localparam logic [5:0] P_LIM = 6'b000100;
  localparam logic [5:0] P_PIN = 6'b000010;
  localparam logic [5:0] P_TMO = 6'b000001;
  localparam logic [63:0] SAT_INI = 64'hFFFF_FFFF_FFFF_FFF6;

  logic        CLK, RESET, TARJETA_RECIBIDA, DIGITO_STB, MONTO_STB, TIPO_TRANS, CANCELAR;
  logic [3:0]  DIGITO;
  logic [15:0] PIN;
  logic [31:0] MONTO;
  logic        BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES, LIMITE_EXCEDIDO;
  logic        PIN_INCORRECTO, ADVERTENCIA, BLOQUEO, TIEMPO_AGOTADO;
  logic [63:0] BALANCE;
  logic        s_bal, s_ent, s_fon, s_lim, s_pin, s_adv, s_blq, s_tmo;
  logic [63:0] s_balance;

  cajero_parametrizado #(
    .N_DIGITOS(4), .MAX_INTENTOS(MAX_INT), .MONTO_W(32), .BALANCE_W(64),
    .BALANCE_INICIAL(64'd1000), .LIMITE_RETIRO(65'd500), .TIMEOUT_CICLOS(16)
  ) dut (
    .CLK(CLK), .RESET(RESET), .TARJETA_RECIBIDA(TARJETA_RECIBIDA),
    .DIGITO_STB(DIGITO_STB), .DIGITO(DIGITO), .PIN(PIN),
    .MONTO_STB(MONTO_STB), .TIPO_TRANS(TIPO_TRANS), .MONTO(MONTO), .CANCELAR(CANCELAR),
    .BALANCE_ACTUALIZADO(BALANCE_ACTUALIZADO), .ENTREGAR_DINERO(ENTREGAR_DINERO),
    .FONDOS_INSUFICIENTES(FONDOS_INSUFICIENTES), .LIMITE_EXCEDIDO(LIMITE_EXCEDIDO),
    .PIN_INCORRECTO(PIN_INCORRECTO), .ADVERTENCIA(ADVERTENCIA), .BLOQUEO(BLOQUEO),
    .TIEMPO_AGOTADO(TIEMPO_AGOTADO), .BALANCE(BALANCE)
  );

  cajero_parametrizado #(
    .N_DIGITOS(4), .MAX_INTENTOS(MAX_INT), .MONTO_W(32), .BALANCE_W(64),
    .BALANCE_INICIAL(SAT_INI), .LIMITE_RETIRO(65'd500), .TIMEOUT_CICLOS(16)
  ) dut_sat (
    .CLK(CLK), .RESET(RESET), .TARJETA_RECIBIDA(TARJETA_RECIBIDA),
    .DIGITO_STB(DIGITO_STB), .DIGITO(DIGITO), .PIN(PIN),
    .MONTO_STB(MONTO_STB), .TIPO_TRANS(TIPO_TRANS), .MONTO(MONTO), .CANCELAR(CANCELAR),
    .BALANCE_ACTUALIZADO(s_bal), .ENTREGAR_DINERO(s_ent),
    .FONDOS_INSUFICIENTES(s_fon), .LIMITE_EXCEDIDO(s_lim),
    .PIN_INCORRECTO(s_pin), .ADVERTENCIA(s_adv), .BLOQUEO(s_blq),
    .TIEMPO_AGOTADO(s_tmo), .BALANCE(s_balance)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0]  pulses;
    logic        adv;
    logic        blq;
    logic [63:0] bal;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk = 0;
  int  n_fail = 0;

  // Account/session model
  logic [63:0] m_bal = 64'd1000;
  longint      m_ret = 0;
  int          m_int = 0;
  logic        m_adv = 1'b0;
  logic        m_locked = 1'b0;
  int          m_session = 0;  // 0 no card, 1 entering PIN, 2 transaction menu
  int          m_digs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic void push(input logic [5:0] p);
    ev_t e;
    e.pulses = p;
    e.adv    = m_adv;
    e.blq    = m_locked;
    e.bal    = m_bal;
    exp_q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic card();
    TARJETA_RECIBIDA = 1'b1;
    tick();
    TARJETA_RECIBIDA = 1'b0;
    if (!m_locked && m_session == 0) begin
      m_session = 1;
      m_digs.delete();
      m_ret = 0;
    end
    tick();
  endtask

  task automatic press(input logic [3:0] d);
    int v;
    DIGITO_STB = 1'b1;
    DIGITO     = d;
    tick();
    DIGITO_STB = 1'b0;
    if (!m_locked && m_session == 1 && d <= 4'd9) begin
      m_digs.push_back(int'(d));
      if (m_digs.size() == 4) begin
        v = 0;
        foreach (m_digs[i]) v = v * 16 + m_digs[i];
        m_digs.delete();
        if (v == int'(PIN)) begin
          m_int = 0;
          m_adv = 1'b0;
          m_session = 2;
        end else begin
          m_int++;
          if (m_int == MAX_INT) begin
            m_locked = 1'b1;
            m_adv = 1'b1;
            push(6'b0);
          end else begin
            m_adv = (m_int == MAX_INT - 1);
            push(P_PIN);
          end
        end
      end
    end
  endtask

  task automatic digit(input logic [3:0] d);
    press(d);
    tick();
    tick();
  endtask

  task automatic enter_pin(input logic [15:0] p);
    for (int i = 3; i >= 0; i--) digit(p[4*i +: 4]);
  endtask

  task automatic tx(input logic tipo, input logic [31:0] amt, input logic with_dig, input logic with_cancel);
    logic [64:0] s;
    MONTO_STB  = 1'b1;
    TIPO_TRANS = tipo;
    MONTO      = amt;
    DIGITO_STB = with_dig;
    DIGITO     = 4'd1;
    CANCELAR   = with_cancel;
    tick();
    MONTO_STB  = 1'b0;
    DIGITO_STB = 1'b0;
    CANCELAR   = 1'b0;
    if (!m_locked) begin
      if (with_cancel) begin
        m_session = 0;
      end else if (m_session == 2) begin
        if (!tipo) begin
          s = {1'b0, m_bal} + {33'b0, amt};
          m_bal = s[64] ? {64{1'b1}} : s[63:0];
          push(P_BAL);
        end else if (64'(amt) > m_bal) begin
          push(P_FON);
        end else if (m_ret + longint'(amt) > 500) begin
          push(P_LIM);
        end else begin
          m_bal = m_bal - 64'(amt);
          m_ret = m_ret + longint'(amt);
          push(P_BAL | P_ENT);
        end
      end
    end
    tick();
    tick();
  endtask

  task automatic cancel();
    CANCELAR = 1'b1;
    tick();
    CANCELAR = 1'b0;
    if (!m_locked) m_session = 0;
    tick();
  endtask

  // Monitor: compare every observed output event against the queue head
  ev_t        mon_e;
  logic [5:0] mon_p;
  logic       blq_prev = 1'b0;
  always @(negedge CLK) begin
    if (RESET === 1'b1) begin
      mon_p = {BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES,
               LIMITE_EXCEDIDO, PIN_INCORRECTO, TIEMPO_AGOTADO};
      if (mon_p != 6'b0 || (BLOQUEO && !blq_prev)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {58'b0, mon_p}, 64'hFFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ev_pulses", {58'b0, mon_p}, {58'b0, mon_e.pulses});
          chk("ev_advertencia", {63'b0, ADVERTENCIA}, {63'b0, mon_e.adv});
          chk("ev_bloqueo", {63'b0, BLOQUEO}, {63'b0, mon_e.blq});
          chk("ev_balance", BALANCE, mon_e.bal);
        end
      end
    end
    blq_prev = BLOQUEO;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int seen;
    logic [3:0] d;
    logic [31:0] amt;
    RESET = 1'b0; TARJETA_RECIBIDA = 1'b0; DIGITO_STB = 1'b0; DIGITO = 4'd0;
    PIN = 16'h1234; MONTO_STB = 1'b0; TIPO_TRANS = 1'b0; MONTO = 32'd0; CANCELAR = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_bal_act", {63'b0, BALANCE_ACTUALIZADO}, 64'd0);
    chk("rst_entregar", {63'b0, ENTREGAR_DINERO}, 64'd0);
    chk("rst_fondos", {63'b0, FONDOS_INSUFICIENTES}, 64'd0);
    chk("rst_limite", {63'b0, LIMITE_EXCEDIDO}, 64'd0);
    chk("rst_pin_inc", {63'b0, PIN_INCORRECTO}, 64'd0);
    chk("rst_advertencia", {63'b0, ADVERTENCIA}, 64'd0);
    chk("rst_bloqueo", {63'b0, BLOQUEO}, 64'd0);
    chk("rst_tiempo", {63'b0, TIEMPO_AGOTADO}, 64'd0);
    chk("rst_balance", BALANCE, 64'd1000);
    chk("rst_balance_sat", s_balance, SAT_INI);
    @(negedge CLK);
    RESET = 1'b1;
    tick();

    // Deposit then withdrawal; near-full instance must saturate
    card();
    enter_pin(16'h1234);
    tx(1'b0, 32'd200, 1'b0, 1'b0);
    chk("sat_balance", s_balance, {64{1'b1}});
    tx(1'b1, 32'd300, 1'b0, 1'b0);
    chk("balance_900", BALANCE, 64'd900);
    cancel();

    // Fresh session: limit, then insufficient funds, then DIGITO+MONTO together
    card();
    enter_pin(16'h1234);
    tx(1'b1, 32'd300, 1'b0, 1'b0);
    tx(1'b1, 32'd250, 1'b0, 1'b0);
    tx(1'b1, 32'd2000, 1'b0, 1'b0);
    tx(1'b0, 32'd10, 1'b1, 1'b0);
    tx(1'b0, 32'd100, 1'b0, 1'b1);
    chk("cancel_beats_strobe", BALANCE, m_bal);

    // Inactivity timeout with a restart on the 15th idle cycle
    card();
    press(4'd1);
    tick();
    press(4'd2);
    repeat (14) tick();
    press(4'd3);
    push(P_TMO);
    m_session = 0;
    seen = 0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (TIEMPO_AGOTADO) begin
        seen = i;
        break;
      end
    end
    chk("timeout_cycles", 64'(seen), 64'd16);
    tick();

    // Two wrong PINs, cancel, correct PIN clears the warning
    card();
    enter_pin(16'h1111);
    enter_pin(16'h2222);
    chk("adv_after_two", {63'b0, ADVERTENCIA}, 64'd1);
    cancel();
    card();
    enter_pin(16'h1234);
    chk("adv_cleared", {63'b0, ADVERTENCIA}, 64'd0);
    tx(1'b0, 32'd50, 1'b0, 1'b0);
    cancel();

    // Randomized sessions
    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 9);
      if (m_session == 0) begin
        if (r < 7) card();
        else if (r == 7) digit(4'($urandom_range(0, 9)));
        else if (r == 8) tx(1'b0, 32'd5, 1'b0, 1'b0);
        else cancel();
      end else if (m_session == 1) begin
        if (r < 8) begin
          if (m_int >= MAX_INT - 1 || $urandom_range(0, 3) != 0) d = PIN[15 - 4*m_digs.size() -: 4];
          else d = 4'($urandom_range(0, 15));
          digit(d);
        end else if (r == 8) cancel();
        else tx(1'b0, 32'd7, 1'b0, 1'b0);
      end else begin
        amt = ($urandom_range(0, 9) == 0) ? 32'd2000 : 32'($urandom_range(1, 350));
        if (r < 3) tx(1'b0, 32'($urandom_range(1, 300)), 1'b0, 1'b0);
        else if (r < 8) tx(1'b1, amt, 1'b0, 1'b0);
        else if (r == 8) tx(1'b1, amt, 1'b1, 1'b0);
        else cancel();
      end
    end

    // Asynchronous reset in the middle of a withdrawal
    cancel();
    card();
    enter_pin(16'h1234);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    MONTO_STB = 1'b1; TIPO_TRANS = 1'b1; MONTO = 32'd100;
    @(posedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    chk("async_rst_balance", BALANCE, 64'd1000);
    chk("async_rst_pulses", {56'b0, BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES,
        LIMITE_EXCEDIDO, PIN_INCORRECTO, ADVERTENCIA, BLOQUEO, TIEMPO_AGOTADO}, 64'd0);
    MONTO_STB = 1'b0;
    exp_q.delete();
    m_bal = 64'd1000; m_ret = 0; m_int = 0; m_adv = 1'b0; m_locked = 1'b0; m_session = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    tick();

    // Three wrong PINs lock; a correct PIN afterwards is ignored
    card();
    enter_pin(16'h1111);
    enter_pin(16'h2222);
    enter_pin(16'h3333);
    chk("bloqueo_set", {63'b0, BLOQUEO}, 64'd1);
    cancel();
    card();
    enter_pin(16'h1234);
    tx(1'b0, 32'd100, 1'b0, 1'b0);
    chk("locked_balance", BALANCE, 64'd1000);
    chk("locked_adv", {63'b0, ADVERTENCIA}, 64'd1);
    repeat (4) tick();
    chk("queue_empty_end", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
